tx_frame_ctrl: RTL and testbench

Frame scheduler for the TX encryption datapath. Drives the TX enable, PRBS reload and PRBS seed controls, and counts accepted stream beats to split the keystream-XORed output into frames of programmable length. Frames are separated by programmable idle gaps. It sits beside the TX datapath and replaces static register control of enable/reload with a sequenced, per-burst schedule that also emits start/end-of-frame markers.

---
 rtl/tx_frame_ctrl.sv | 144 ++++++++++++++
 tb/tb_tx_frame_ctrl.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/tx_frame_ctrl.sv
// Burst/frame scheduler for the TX encryption datapath: sequences PRBS reload,
// datapath enable and idle gaps, and marks frame boundaries on accepted beats.
module tx_frame_ctrl #(
  parameter int C_LEN_WIDTH  = 16,
  parameter int C_SEED_WIDTH = 32
) (
  input  logic                    s_axi_aclk,
  input  logic                    s_axi_aresetn,
  input  logic                    i_start,
  input  logic                    i_abort,
  input  logic [C_LEN_WIDTH-1:0]  i_frame_len,
  input  logic [C_LEN_WIDTH-1:0]  i_gap_len,
  input  logic [C_LEN_WIDTH-1:0]  i_frame_count,
  input  logic [C_SEED_WIDTH-1:0] i_seed,
  input  logic                    i_beat,
  output logic                    o_tx_enable,
  output logic                    o_prbs_reload,
  output logic [C_SEED_WIDTH-1:0] o_prbs_seed,
  output logic                    o_sof,
  output logic                    o_eof,
  output logic                    o_busy,
  output logic                    o_done,
  output logic                    o_err_len,
  output logic [C_LEN_WIDTH-1:0]  o_frames_sent
);

  typedef enum logic [1:0] {IDLE, LOAD, RUN, GAP} state_t;

  localparam logic [C_LEN_WIDTH-1:0] LEN_ONE = 1;

  state_t                  state_q, state_d;
  logic [C_LEN_WIDTH-1:0]  frame_len_q, gap_len_q, frame_count_q;
  logic [C_LEN_WIDTH-1:0]  beat_cnt_q, beat_cnt_d;
  logic [C_LEN_WIDTH-1:0]  gap_cnt_q, gap_cnt_d;
  logic [C_LEN_WIDTH-1:0]  frames_sent_q, frames_sent_d;
  logic [C_LEN_WIDTH-1:0]  frames_inc;
  logic [C_SEED_WIDTH-1:0] seed_q;
  logic                    done_q, done_d;
  logic                    err_q, err_d;
  logic                    latch_cfg;
  logic                    last_beat;

  assign last_beat  = (beat_cnt_q == frame_len_q - LEN_ONE);
  assign frames_inc = frames_sent_q + LEN_ONE;

  always_comb begin
    state_d       = state_q;
    beat_cnt_d    = beat_cnt_q;
    gap_cnt_d     = gap_cnt_q;
    frames_sent_d = frames_sent_q;
    done_d        = 1'b0;
    err_d         = 1'b0;
    latch_cfg     = 1'b0;
    case (state_q)
      IDLE: begin
        // abort beats start when both arrive together
        if (i_start && !i_abort) begin
          if (i_frame_len == '0) begin
            err_d = 1'b1;
          end else begin
            latch_cfg     = 1'b1;
            beat_cnt_d    = '0;
            gap_cnt_d     = '0;
            frames_sent_d = '0;
            state_d       = LOAD;
          end
        end
      end
      LOAD: begin
        state_d = i_abort ? IDLE : RUN;
      end
      RUN: begin
        if (i_abort) begin
          state_d = IDLE;
        end else if (i_beat) begin
          if (last_beat) begin
            beat_cnt_d    = '0;
            frames_sent_d = frames_inc;
            if (frame_count_q != '0 && frames_inc == frame_count_q) begin
              state_d = IDLE;
              done_d  = 1'b1;
            end else if (gap_len_q != '0) begin
              state_d   = GAP;
              gap_cnt_d = '0;
            end
          end else begin
            beat_cnt_d = beat_cnt_q + LEN_ONE;
          end
        end
      end
      GAP: begin
        if (i_abort) begin
          state_d = IDLE;
        end else if (gap_cnt_q == gap_len_q - LEN_ONE) begin
          state_d = RUN;
        end else begin
          gap_cnt_d = gap_cnt_q + LEN_ONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge s_axi_aclk) begin
    if (!s_axi_aresetn) begin
      state_q       <= IDLE;
      frame_len_q   <= '0;
      gap_len_q     <= '0;
      frame_count_q <= '0;
      seed_q        <= '0;
      beat_cnt_q    <= '0;
      gap_cnt_q     <= '0;
      frames_sent_q <= '0;
      done_q        <= 1'b0;
      err_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      beat_cnt_q    <= beat_cnt_d;
      gap_cnt_q     <= gap_cnt_d;
      frames_sent_q <= frames_sent_d;
      done_q        <= done_d;
      err_q         <= err_d;
      if (latch_cfg) begin
        frame_len_q   <= i_frame_len;
        gap_len_q     <= i_gap_len;
        frame_count_q <= i_frame_count;
        seed_q        <= i_seed;
      end
    end
  end

  // Enable/reload/markers decode straight from state so the cycle after a
  // frame's last beat already has enable low.
  assign o_tx_enable   = (state_q == RUN);
  assign o_prbs_reload = (state_q == LOAD);
  assign o_prbs_seed   = seed_q;
  assign o_sof         = (state_q == RUN) && (beat_cnt_q == '0);
  assign o_eof         = (state_q == RUN) && last_beat;
  assign o_busy        = (state_q != IDLE);
  assign o_done        = done_q;
  assign o_err_len     = err_q;
  assign o_frames_sent = frames_sent_q;

endmodule

// File: tb/tb_tx_frame_ctrl.sv
// Scoreboard bench for tx_frame_ctrl: expected {sof,eof} per accepted beat are
// queued by the stimulus and popped by a negedge monitor.
module tb_tx_frame_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_start, i_abort, i_beat;
  logic [15:0] i_frame_len, i_gap_len, i_frame_count;
  logic [31:0] i_seed;
  logic        o_tx_enable, o_prbs_reload, o_sof, o_eof, o_busy, o_done, o_err_len;
  logic [31:0] o_prbs_seed;
  logic [15:0] o_frames_sent;

  int n_checks = 0;
  int n_errors = 0;
  int n_beats, n_reload, n_done, n_err;
  logic [1:0] exp_q[$];
  logic [17:0] trace;

  always #5 clk = ~clk;

  tx_frame_ctrl #(.C_LEN_WIDTH(16), .C_SEED_WIDTH(32)) dut (
    .s_axi_aclk    (clk),
    .s_axi_aresetn (rst_n),
    .i_start       (i_start),
    .i_abort       (i_abort),
    .i_frame_len   (i_frame_len),
    .i_gap_len     (i_gap_len),
    .i_frame_count (i_frame_count),
    .i_seed        (i_seed),
    .i_beat        (i_beat),
    .o_tx_enable   (o_tx_enable),
    .o_prbs_reload (o_prbs_reload),
    .o_prbs_seed   (o_prbs_seed),
    .o_sof         (o_sof),
    .o_eof         (o_eof),
    .o_busy        (o_busy),
    .o_done        (o_done),
    .o_err_len     (o_err_len),
    .o_frames_sent (o_frames_sent)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // A beat is accepted at the next edge when enable and beat are both high.
  always @(negedge clk) begin
    if (rst_n) begin
      if (o_prbs_reload) n_reload++;
      if (o_done) n_done++;
      if (o_err_len) n_err++;
      if (o_tx_enable && i_beat && !i_abort) begin
        n_beats++;
        if (exp_q.size() == 0) check("extra_beat", 1, 0);
        else check("sof_eof", {o_sof, o_eof}, exp_q.pop_front());
      end
    end
  end

  task automatic clear_counts();
    n_beats = 0; n_reload = 0; n_done = 0; n_err = 0;
  endtask

  // Called at posedge+1; returns at posedge+1 of the LOAD cycle.
  task automatic start_burst(input logic [15:0] len, input logic [15:0] gap,
                             input logic [15:0] cnt, input logic [31:0] seed);
    i_frame_len = len; i_gap_len = gap; i_frame_count = cnt; i_seed = seed;
    i_start = 1'b1;
    @(posedge clk); #1;
    i_start = 1'b0;
  endtask

  task automatic push_frames(input int len, input int frames);
    for (int f = 0; f < frames; f++)
      for (int b = 0; b < len; b++)
        exp_q.push_back({b == 0, b == len - 1});
  endtask

  task automatic wait_beats(input int target);
    for (int i = 0; i < 100 && n_beats < target; i++) @(posedge clk);
    if (n_beats < target) check("wait_beats_timeout", n_beats, target);
    #1;
  endtask

  task automatic check_drained(input string tag);
    check(tag, exp_q.size(), 0);
    exp_q.delete();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0; i_start = 0; i_abort = 0; i_beat = 0;
    i_frame_len = 0; i_gap_len = 0; i_frame_count = 0; i_seed = 0;
    clear_counts();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_outputs", {o_tx_enable, o_prbs_reload, o_prbs_seed, o_sof, o_eof,
                            o_busy, o_done, o_err_len, o_frames_sent}, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // len 4, gap 2, count 3, beat held high
    clear_counts();
    push_frames(4, 3);
    i_beat = 1'b1;
    start_burst(16'd4, 16'd2, 16'd3, 32'hDEADBEEF);
    trace = '0;
    for (int i = 0; i < 18; i++) begin
      @(negedge clk);
      if (i == 0) begin
        check("t1_reload", o_prbs_reload, 1);
        check("t1_busy_load", o_busy, 1);
        check("t1_seed", o_prbs_seed, 32'hDEADBEEF);
      end
      if (i == 1) check("t1_sof_first", o_sof, 1);
      trace = {trace[16:0], o_tx_enable};
    end
    @(posedge clk); #1;
    i_beat = 1'b0;
    repeat (2) @(posedge clk); #1;
    check("t1_enable_trace", trace, 18'b0_1111_00_1111_00_1111_0);
    check("t1_reload_count", n_reload, 1);
    check("t1_done_count", n_done, 1);
    check("t1_frames_sent", o_frames_sent, 3);
    check("t1_busy_end", o_busy, 0);
    check_drained("t1_missing_beats");

    // len 1, gap 0, count 5, beat toggling
    clear_counts();
    push_frames(1, 5);
    start_burst(16'd1, 16'd0, 16'd5, 32'h12345678);
    for (int i = 0; i < 16; i++) begin
      i_beat = ~i_beat;
      @(posedge clk); #1;
    end
    i_beat = 1'b0;
    repeat (2) @(posedge clk); #1;
    check("t2_beats", n_beats, 5);
    check("t2_done_count", n_done, 1);
    check("t2_frames_sent", o_frames_sent, 5);
    check("t2_enable_end", o_tx_enable, 0);
    check_drained("t2_missing_beats");

    // frame_len 0 is rejected
    clear_counts();
    start_burst(16'd0, 16'd1, 16'd1, 32'hAAAA5555);
    @(negedge clk);
    check("t3_err_pulse", o_err_len, 1);
    check("t3_busy", o_busy, 0);
    @(negedge clk);
    check("t3_err_single", o_err_len, 0);
    @(posedge clk); #1;
    check("t3_err_count", n_err, 1);
    check("t3_no_reload", n_reload, 0);
    check("t3_frames_kept", o_frames_sent, 5);
    check("t3_seed_kept", o_prbs_seed, 32'h12345678);

    // continuous mode, abort after 7 beats
    clear_counts();
    push_frames(3, 2);
    push_frames(1, 1);
    exp_q[6] = 2'b10;
    i_beat = 1'b1;
    start_burst(16'd3, 16'd0, 16'd0, 32'hCAFEF00D);
    wait_beats(7);
    i_beat = 1'b0; i_abort = 1'b1;
    @(posedge clk); #1;
    i_abort = 1'b0;
    @(negedge clk);
    check("t4_busy_after_abort", o_busy, 0);
    check("t4_frames_sent", o_frames_sent, 2);
    @(posedge clk); #1;
    check("t4_no_done", n_done, 0);
    check_drained("t4_missing_beats");
    clear_counts();
    start_burst(16'd3, 16'd0, 16'd0, 32'h1);
    @(negedge clk);
    check("t4_restart_reload", o_prbs_reload, 1);
    check("t4_restart_seed", o_prbs_seed, 32'h1);
    check("t4_restart_frames_clear", o_frames_sent, 0);
    @(posedge clk); #1;
    i_abort = 1'b1;
    @(posedge clk); #1;
    i_abort = 1'b0;
    @(negedge clk);
    check("t4_restart_abort", o_busy, 0);
    @(posedge clk); #1;

    // start during RUN is ignored; start+abort in IDLE does nothing
    clear_counts();
    push_frames(2, 2);
    start_burst(16'd2, 16'd0, 16'd2, 32'h0BADC0DE);
    @(posedge clk); #1;
    i_frame_len = 16'd5; i_frame_count = 16'd7; i_gap_len = 16'd3; i_seed = 32'h99;
    i_start = 1'b1;
    @(posedge clk); #1;
    i_start = 1'b0;
    i_beat = 1'b1;
    repeat (8) @(posedge clk); #1;
    i_beat = 1'b0;
    check("t5_reload_count", n_reload, 1);
    check("t5_done_count", n_done, 1);
    check("t5_frames_sent", o_frames_sent, 2);
    check("t5_seed", o_prbs_seed, 32'h0BADC0DE);
    check_drained("t5_missing_beats");
    clear_counts();
    i_start = 1'b1; i_abort = 1'b1;
    @(posedge clk); #1;
    i_start = 1'b0; i_abort = 1'b0;
    @(negedge clk);
    check("t5_start_abort_busy", o_busy, 0);
    @(posedge clk); #1;
    check("t5_start_abort_reload", n_reload, 0);

    // reset asserted while in GAP
    clear_counts();
    push_frames(2, 1);
    i_beat = 1'b1;
    start_burst(16'd2, 16'd5, 16'd3, 32'h77777777);
    wait_beats(2);
    rst_n = 1'b0; i_beat = 1'b0;
    @(negedge clk);
    check("t6_in_gap", {o_busy, o_tx_enable}, 2'b10);
    @(negedge clk);
    check("t6_reset_outputs", {o_tx_enable, o_prbs_reload, o_prbs_seed, o_sof, o_eof,
                               o_busy, o_done, o_err_len, o_frames_sent}, 0);
    check_drained("t6_missing_beats");
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    clear_counts();
    push_frames(1, 1);
    i_beat = 1'b1;
    start_burst(16'd1, 16'd0, 16'd1, 32'h55);
    repeat (4) @(posedge clk); #1;
    i_beat = 1'b0;
    check("t6_post_reset_done", n_done, 1);
    check("t6_post_reset_frames", o_frames_sent, 1);
    check("t6_post_reset_seed", o_prbs_seed, 32'h55);
    check("t6_post_reset_reload", n_reload, 1);
    check_drained("t6_post_missing_beats");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
